systolic_feeder: RTL and testbench

//  Drives the west (in_a) edge of the N-row systolic MAC array: accepts one N-element

---
 rtl/systolic_feeder.sv | 155 +++++++++++++++
 tb/tb_systolic_feeder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// systolic_feeder: west-edge operand feeder for an N-row systolic MAC array.
// Takes one N-lane operand vector per cycle and skews it diagonally so that
// lane i reaches array row i exactly i cycles after lane 0. A small FSM tracks
// the tile (IDLE/FILL/FLUSH) and pulses done when the last vector's final lane
// leaves the feeder. The shared array pause freezes every register.
//
// Optional build macro: FEEDER_PERF_CNT_EN adds the stall_cnt / vec_cnt
// performance counters and their output ports.
//
// state | meaning
// IDLE  | no tile in progress, ready for the first vector of a tile
// FILL  | tile in progress, more vectors expected
// FLUSH | last vector taken; draining skew chains, input blocked

module systolic_feeder #(
    parameter int DATA_SIZE = 8,
    parameter int N         = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*DATA_SIZE-1:0] in_data,
    input  logic                   in_last,
    input  logic                   pause,
    output logic [N*DATA_SIZE-1:0] out_a,
    output logic [N-1:0]           out_vld,
    output logic                   busy,
    output logic                   done
`ifdef FEEDER_PERF_CNT_EN
    ,
    output logic [15:0]            stall_cnt,
    output logic [15:0]            vec_cnt
`endif
);

    localparam int CNT_W = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               accept;

    assign in_ready = !reset && !pause && (state_q != FLUSH);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

    // Per-lane skew chains: lane i is i+1 registers deep, the last one drives out_a.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DATA_SIZE-1:0] data_q [0:i];
        logic [i:0]           vld_q;

        // Shift the lane chain on every non-paused cycle; bubbles inject zero.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int j = 0; j <= i; j++) begin
                    data_q[j] <= '0;
                end
                vld_q <= '0;
            end else if (!pause) begin
                data_q[0] <= accept ? in_data[i*DATA_SIZE +: DATA_SIZE] : '0;
                vld_q[0]  <= accept;
                for (int j = 1; j <= i; j++) begin
                    data_q[j] <= data_q[j-1];
                    vld_q[j]  <= vld_q[j-1];
                end
            end
        end

        assign out_a[i*DATA_SIZE +: DATA_SIZE] = data_q[i];
        assign out_vld[i]                      = vld_q[i];
    end

    // FSM state, flush counter and done pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; a paused cycle leaves everything unchanged.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        if (!pause) begin
            done_d = 1'b0;
            case (state_q)
                IDLE, FILL: begin
                    if (accept) begin
                        if (in_last) begin
                            state_d = FLUSH;
                            cnt_d   = CNT_W'(N - 1);
                        end else begin
                            state_d = FILL;
                        end
                    end
                end
                FLUSH: begin
                    // Counter reaches zero on the same edge that lane N-1 shows
                    // the last vector's final element.
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

`ifdef FEEDER_PERF_CNT_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] vec_cnt_q;

    // Tile statistics: restart at tile start, saturate at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            vec_cnt_q   <= '0;
        end else if (accept && (state_q == IDLE)) begin
            stall_cnt_q <= '0;
            vec_cnt_q   <= 16'd1;
        end else begin
            if (accept && (vec_cnt_q != 16'hFFFF)) begin
                vec_cnt_q <= vec_cnt_q + 16'd1;
            end
            if (busy && pause && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign vec_cnt   = vec_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Testbench for systolic_feeder (N=4, DATA_SIZE=8).
// The driver pushes per-lane expected elements and the expected done slot into
// queues when a vector is accepted; the monitor pops them whenever the DUT
// shows a valid lane or a done pulse on a non-paused cycle.

module tb_systolic_feeder;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N*DW-1:0] in_data = '0;
    logic            in_last = 1'b0;
    logic            pause = 1'b0;
    logic [N*DW-1:0] out_a;
    logic [N-1:0]    out_vld;
    logic            busy;
    logic            done;
`ifdef FEEDER_PERF_CNT_EN
    logic [15:0]     stall_cnt;
    logic [15:0]     vec_cnt;
`endif

    systolic_feeder #(.DATA_SIZE(DW), .N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .pause    (pause),
        .out_a    (out_a),
        .out_vld  (out_vld),
        .busy     (busy),
        .done     (done)
`ifdef FEEDER_PERF_CNT_EN
        ,
        .stall_cnt(stall_cnt),
        .vec_cnt  (vec_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int         edge_n;
    } exp_t;

    exp_t lane_q [N][$];
    int   done_q [$];

    int checks = 0;
    int errors = 0;
    int act_cnt = 0;
    int cyc = 0;
    bit edge_live = 1'b0;

    logic [7:0] mon_v;
    exp_t       mon_e;
    int         mon_d;

    // Count live (not reset, not paused) edges; expected timing is in these units.
    always @(posedge clk) begin
        cyc++;
        edge_live = !reset && !pause;
        if (edge_live) act_cnt++;
    end

    // Monitor: compare every lane and done after each live edge.
    always @(negedge clk) begin
        if (edge_live && !reset) begin
            for (int i = 0; i < N; i++) begin
                mon_v = out_a[i*DW +: DW];
                checks++;
                if (out_vld[i]) begin
                    if (lane_q[i].size() == 0) begin
                        errors++;
                        $display("FAIL lane%0d_unexpected: got vld=1 data=%h, expected no valid", i, mon_v);
                    end else begin
                        mon_e = lane_q[i].pop_front();
                        if (mon_v !== mon_e.d || act_cnt != mon_e.edge_n) begin
                            errors++;
                            $display("FAIL lane%0d_data: got %h at edge %0d, expected %h at edge %0d",
                                     i, mon_v, act_cnt, mon_e.d, mon_e.edge_n);
                        end
                    end
                end else if (mon_v !== 8'h00) begin
                    errors++;
                    $display("FAIL lane%0d_bubble: got %h with vld=0, expected 00", i, mon_v);
                end
            end
            if (done) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: got done=1 at edge %0d, expected 0", act_cnt);
                end else begin
                    mon_d = done_q.pop_front();
                    if (mon_d != act_cnt) begin
                        errors++;
                        $display("FAIL done_time: got edge %0d, expected edge %0d", act_cnt, mon_d);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Drive one cycle starting at posedge+1; record expectations if it is accepted.
    task automatic send(input logic v, input logic [N*DW-1:0] d, input logic last);
        int e;
        in_valid = v;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        if (v && in_ready) begin
            e = act_cnt + 1;
            for (int i = 0; i < N; i++) begin
                lane_q[i].push_back('{d: d[i*DW +: DW], edge_n: e + i});
            end
            if (last) done_q.push_back(e + N - 1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) send(1'b0, '0, 1'b0);
    endtask

    function automatic logic [N*DW-1:0] vec(input int k);
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = 8'(16 * k + i);
        return r;
    endfunction

    logic [N*DW-1:0] snap_a;
    logic [N-1:0]    snap_v;
    int              c0;
    int              done_cyc;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Test 1: reset mid-FILL
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);
        check("ready_after_init", 32'(in_ready), 32'd1);
        send(1'b1, vec(5), 1'b0);
        send(1'b1, vec(6), 1'b0);
        check("busy_fill", 32'(busy), 32'd1);
        reset = 1'b1;
        for (int i = 0; i < N; i++) lane_q[i].delete();
        done_q.delete();
        #2;
        check("rst_out_a", out_a, '0);
        check("rst_out_vld", 32'(out_vld), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("ready_after_rst", 32'(in_ready), 32'd1);
        idle(6);

        // Test 2: single vector with in_last
        send(1'b1, {8'h04, 8'h03, 8'h02, 8'h01}, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            check("ready_flush", 32'(in_ready), 32'd0);
            idle(1);
        end
        check("ready_done_cycle", 32'(in_ready), 32'd1);
        check("done_t_plus_4", 32'(done), 32'd1);
        idle(3);

        // Test 3: three back-to-back vectors
        send(1'b1, vec(0), 1'b0);
        send(1'b1, vec(1), 1'b0);
        send(1'b1, vec(2), 1'b1);
        idle(7);

        // Test 4: signed extremes separated by a bubble
        send(1'b1, {N{8'h80}}, 1'b0);
        idle(1);
        send(1'b1, {N{8'h7F}}, 1'b1);
        idle(7);

        // Test 5: pause during FLUSH
        send(1'b1, {8'h44, 8'h33, 8'h22, 8'h11}, 1'b1);
        c0 = cyc;
        snap_a = out_a;
        snap_v = out_vld;
        pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("pause_out_a", out_a, snap_a);
            check("pause_out_vld", 32'(out_vld), 32'(snap_v));
            check("pause_ready", 32'(in_ready), 32'd0);
            check("pause_done", 32'(done), 32'd0);
        end
        pause = 1'b0;
        done_cyc = -1;
        for (int k = 0; k < 20 && done_cyc < 0; k++) begin
            @(negedge clk);
            if (done) done_cyc = cyc;
        end
        check("done_delay", 32'(done_cyc - c0), 32'd6);
`ifdef FEEDER_PERF_CNT_EN
        check("stall_cnt", 32'(stall_cnt), 32'd3);
        check("vec_cnt", 32'(vec_cnt), 32'd1);
`endif
        @(posedge clk);
        #1;
        idle(2);

`ifdef FEEDER_PERF_CNT_EN
        // Test 6: next tile start clears the counters
        send(1'b1, vec(3), 1'b0);
        check("stall_cnt_clr", 32'(stall_cnt), 32'd0);
        check("vec_cnt_clr", 32'(vec_cnt), 32'd1);
        send(1'b1, vec(4), 1'b1);
        check("vec_cnt_2", 32'(vec_cnt), 32'd2);
        idle(6);
`endif

        idle(4);
        for (int i = 0; i < N; i++) check("lane_queue_empty", 32'(lane_q[i].size()), 32'd0);
        check("done_queue_empty", 32'(done_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
